collision_game_fsm: RTL

//  Game-state controller downstream of the car controller. Consumes car X/Y and frog X/Y in 40x30 tile units.

---
 rtl/collision_game_fsm_pkg.sv | 32 +++
 rtl/collision_game_fsm_if.sv | 40 ++++
 rtl/collision_game_fsm_hold_timer.sv | 47 ++++
 rtl/collision_game_fsm.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/collision_game_fsm_pkg.sv
// -----------------------------------------------------------------------------
// collision_game_fsm_pkg
// Shared game parameters for the collision/score controller:
//   - game_state_t : FSM state encoding (IDLE=0, RUN=1, HIT=2, OVER=3)
//   - playfield size, frog start tile, goal row, default lives / hold time
//   - pos_match()  : tile-coordinate equality used by the collision compare
// -----------------------------------------------------------------------------
package collision_game_fsm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2,
      ST_OVER = 2'd3
   } game_state_t;

   localparam int c_POS_W         = 32'd6;
   localparam int c_GAME_WIDTH    = 32'd40;
   localparam int c_GAME_HEIGHT   = 32'd30;
   localparam int c_START_X       = 32'd20;
   localparam int c_START_Y       = 32'd29;
   localparam int c_GOAL_ROW_DEF  = 32'd0;
   localparam int c_LIVES_DEF     = 32'd3;
   localparam int c_HIT_HOLD_DEF  = 32'd25000000;

   // Two tiles overlap only when both coordinates agree.
   function automatic logic pos_match(input logic [5:0] ax, input logic [5:0] ay,
                                      input logic [5:0] bx, input logic [5:0] by);
      return (ax == bx) && (ay == by);
   endfunction

endpackage

// File: rtl/collision_game_fsm_if.sv
// -----------------------------------------------------------------------------
// collision_game_fsm_if
// Bundle between the movers (car/frog controllers) and the game controller.
//   i_Start        debounced start button (level)
//   i_Frog_X/Y     frog tile position
//   i_Car_X/Y      car tile position
//   o_Game_Active  high only while the game runs
//   o_Frog_Reset   one-cycle pulse returning the frog to its start tile
//   o_Lives        remaining lives
//   o_Score        goals reached (saturating)
//   o_Game_Over    high only in the game-over state
//   o_Flash        hit flash indicator
// master: side that supplies positions/start; slave: the game controller.
// -----------------------------------------------------------------------------
interface collision_game_fsm_if;
   import collision_game_fsm_pkg::*;

   logic               i_Start;
   logic [c_POS_W-1:0] i_Frog_X;
   logic [c_POS_W-1:0] i_Frog_Y;
   logic [c_POS_W-1:0] i_Car_X;
   logic [c_POS_W-1:0] i_Car_Y;
   logic               o_Game_Active;
   logic               o_Frog_Reset;
   logic [3:0]         o_Lives;
   logic [7:0]         o_Score;
   logic               o_Game_Over;
   logic               o_Flash;

   modport master (
      output i_Start, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y,
      input  o_Game_Active, o_Frog_Reset, o_Lives, o_Score, o_Game_Over, o_Flash
   );

   modport slave (
      input  i_Start, i_Frog_X, i_Frog_Y, i_Car_X, i_Car_Y,
      output o_Game_Active, o_Frog_Reset, o_Lives, o_Score, o_Game_Over, o_Flash
   );

endinterface

// File: rtl/collision_game_fsm_hold_timer.sv
// -----------------------------------------------------------------------------
// collision_game_fsm_hold_timer
// Loadable up-counter counting 0..c_HOLD-1, wrapping to 0, with a
// terminal-count flag while enabled at the last count.
//   i_Clk   clock
//   i_Rst   synchronous active-high reset (count := 0)
//   i_Load  synchronous clear to 0 (has priority over i_En)
//   i_En    advance the count
//   o_Tc    high while enabled and the count sits at c_HOLD-1
// -----------------------------------------------------------------------------
module collision_game_fsm_hold_timer #(
   parameter int c_HOLD = 32'd4
) (
   input  logic i_Clk,
   input  logic i_Rst,
   input  logic i_Load,
   input  logic i_En,
   output logic o_Tc
);

   localparam int CW = $clog2(c_HOLD + 32'd1);
   localparam logic [CW-1:0] TC_VAL = CW'(c_HOLD - 32'd1);

   logic [CW-1:0] count_r;
   logic          at_tc_s;

   assign at_tc_s = (count_r == TC_VAL);
   assign o_Tc    = i_En & ~i_Load & at_tc_s;

   // Hold counter: clear on reset/load, advance when enabled, wrap at terminal.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         count_r <= {CW{1'b0}};
      end else if (i_Load) begin
         count_r <= {CW{1'b0}};
      end else if (i_En) begin
         if (at_tc_s) begin
            count_r <= {CW{1'b0}};
         end else begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
         end
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/collision_game_fsm.sv
// -----------------------------------------------------------------------------
// collision_game_fsm
// Game-state controller: detects frog/car collisions and goal reach, keeps
// lives and score, and tells the movers when the game is active.
//   i_Clk   system clock
//   i_Rst   synchronous active-high reset
//   bus     collision_game_fsm_if.slave (start, positions in; status out)
// Positions are registered once and compared on the registered copies, so a
// position change shows its effect on the outputs two edges later.
// All outputs are registered.
// Optional feature macro: HIT_FLASH_EN -- when defined, o_Flash toggles every
// c_HIT_HOLD/8 cycles while in HIT; otherwise o_Flash is tied to 0.
// -----------------------------------------------------------------------------
module collision_game_fsm
   import collision_game_fsm_pkg::*;
#(
   parameter int c_LIVES    = c_LIVES_DEF,
   parameter int c_HIT_HOLD = c_HIT_HOLD_DEF,
   parameter int c_GOAL_ROW = c_GOAL_ROW_DEF
) (
   input  logic                 i_Clk,
   input  logic                 i_Rst,
   collision_game_fsm_if.slave  bus
);

   localparam logic [3:0]         LIVES_INIT = 4'(c_LIVES);
   localparam logic [c_POS_W-1:0] GOAL_Y     = c_POS_W'(c_GOAL_ROW);

   game_state_t        state_r;
   logic               start_r;
   logic [c_POS_W-1:0] frog_x_r, frog_y_r, car_x_r, car_y_r;
   logic               arm_r;
   logic [3:0]         lives_r;
   logic [7:0]         score_r;
   logic               active_r;
   logic               frog_reset_r;
   logic               over_r;

   logic               rise_s;
   logic               collide_s;
   logic               goal_s;
   logic               hold_load_s;
   logic               hold_en_s;
   logic               hold_tc_s;

   assign rise_s      = bus.i_Start & ~start_r;
   assign collide_s   = pos_match(frog_x_r, frog_y_r, car_x_r, car_y_r);
   assign goal_s      = (frog_y_r == GOAL_Y) & arm_r;
   assign hold_load_s = (state_r == ST_RUN) & collide_s;
   assign hold_en_s   = (state_r == ST_HIT);

   // Input stage: start-edge register and one register on every position.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         start_r  <= 1'b0;
         frog_x_r <= {c_POS_W{1'b0}};
         frog_y_r <= {c_POS_W{1'b0}};
         car_x_r  <= {c_POS_W{1'b0}};
         car_y_r  <= {c_POS_W{1'b0}};
      end else begin
         start_r  <= bus.i_Start;
         frog_x_r <= bus.i_Frog_X;
         frog_y_r <= bus.i_Frog_Y;
         car_x_r  <= bus.i_Car_X;
         car_y_r  <= bus.i_Car_Y;
      end
   end

   collision_game_fsm_hold_timer #(
      .c_HOLD (c_HIT_HOLD)
   ) u_hold_timer (
      .i_Clk  (i_Clk),
      .i_Rst  (i_Rst),
      .i_Load (hold_load_s),
      .i_En   (hold_en_s),
      .o_Tc   (hold_tc_s)
   );

   // Game FSM with registered status outputs, lives, score and goal arm.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_r      <= ST_IDLE;
         lives_r      <= LIVES_INIT;
         score_r      <= 8'd0;
         arm_r        <= 1'b0;
         active_r     <= 1'b0;
         frog_reset_r <= 1'b0;
         over_r       <= 1'b0;
      end else begin
         frog_reset_r <= 1'b0;
         case (state_r)
            ST_IDLE, ST_OVER: begin
               if (rise_s) begin
                  state_r      <= ST_RUN;
                  lives_r      <= LIVES_INIT;
                  score_r      <= 8'd0;
                  arm_r        <= 1'b0;
                  active_r     <= 1'b1;
                  frog_reset_r <= 1'b1;
                  over_r       <= 1'b0;
               end else begin
                  active_r     <= 1'b0;
                  over_r       <= (state_r == ST_OVER);
               end
            end
            ST_RUN: begin
               // Collision takes priority over a goal in the same cycle.
               if (collide_s) begin
                  state_r      <= ST_HIT;
                  lives_r      <= lives_r - 4'd1;
                  active_r     <= 1'b0;
               end else if (goal_s) begin
                  if (score_r != 8'd255) begin
                     score_r   <= score_r + 8'd1;
                  end else begin
                     score_r   <= score_r;
                  end
                  arm_r        <= 1'b0;
                  frog_reset_r <= 1'b1;
               end else if (frog_y_r != GOAL_Y) begin
                  // Frog has left the goal row: the next arrival may score.
                  arm_r        <= 1'b1;
               end else begin
                  arm_r        <= arm_r;
               end
            end
            ST_HIT: begin
               if (hold_tc_s) begin
                  if (lives_r == 4'd0) begin
                     state_r      <= ST_OVER;
                     over_r       <= 1'b1;
                  end else begin
                     state_r      <= ST_RUN;
                     active_r     <= 1'b1;
                     frog_reset_r <= 1'b1;
                     arm_r        <= 1'b0;
                  end
               end else begin
                  state_r <= ST_HIT;
               end
            end
            default: begin
               state_r  <= ST_IDLE;
               active_r <= 1'b0;
               over_r   <= 1'b0;
            end
         endcase
      end
   end

`ifdef HIT_FLASH_EN
   localparam int FP = ((c_HIT_HOLD / 32'd8) >= 32'd1) ? (c_HIT_HOLD / 32'd8) : 32'd1;
   localparam int FW = $clog2(FP + 32'd1);
   localparam logic [FW-1:0] FP_LAST = FW'(FP - 32'd1);

   logic [FW-1:0] flash_div_r;
   logic          flash_r;

   // Flash divider: toggle while holding in HIT, forced low on HIT exit.
   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         flash_div_r <= {FW{1'b0}};
         flash_r     <= 1'b0;
      end else if ((state_r == ST_HIT) && !hold_tc_s) begin
         if (flash_div_r == FP_LAST) begin
            flash_div_r <= {FW{1'b0}};
            flash_r     <= ~flash_r;
         end else begin
            flash_div_r <= flash_div_r + {{(FW-1){1'b0}}, 1'b1};
         end
      end else begin
         flash_div_r <= {FW{1'b0}};
         flash_r     <= 1'b0;
      end
   end

   assign bus.o_Flash = flash_r;
`else
   assign bus.o_Flash = 1'b0;
`endif

   assign bus.o_Game_Active = active_r;
   assign bus.o_Frog_Reset  = frog_reset_r;
   assign bus.o_Lives       = lives_r;
   assign bus.o_Score       = score_r;
   assign bus.o_Game_Over   = over_r;

endmodule
